// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: weight-tile load sequencer.
// It reads K weight rows from the weight BRAM through bram_control.
// Each row is shifted into the weight_preload chain as it arrives.
// The unused rows of the MAX_K-deep chain are then flushed with zero shifts.
// A single load_MAC_weight pulse commits the tile into the MAC array.
// All outputs are decoded from registered state only.
module weight_load_ctrl #(
  parameter int BRAM_ADDRESS_WIDTH = 12,
  parameter int MAX_K              = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [4:0]                    kernel_size,
  input  logic [BRAM_ADDRESS_WIDTH-1:0] base_addr,
  output logic                          bram_rd_en,
  output logic [BRAM_ADDRESS_WIDTH-1:0] bram_addr,
  input  logic                          bram_rd_valid,
  output logic                          load_weight_preload,
  output logic                          zero_fill,
  output logic                          load_MAC_weight,
  output logic                          busy,
  output logic                          done,
  output logic                          err_kernel
);

  localparam int         AW      = BRAM_ADDRESS_WIDTH;
  localparam logic [4:0] MAX_K_L = 5'(MAX_K);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SHIFT,
    S_PAD,
    S_COMMIT,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      k_q, k_d;        // latched kernel size
  logic [4:0]      row_q, row_d;    // data row index, then pad row index
  logic [AW-1:0]   base_q, base_d;  // latched tile base row
  logic [AW-1:0]   addr_q, addr_d;  // registered BRAM address, held between reads
  logic            err_q, err_d;    // one-cycle illegal-kernel flag

  logic            k_legal;

  // A start request is legal only for kernel sizes 1..MAX_K.
  assign k_legal = (kernel_size != 5'd0) && (kernel_size <= MAX_K_L);

  // State and counter registers; reset aborts any load in flight at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      row_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      row_q   <= row_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic for the fetch/shift/pad/commit sequence.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    row_d   = row_q;
    base_d  = base_q;
    addr_d  = addr_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        row_d = '0;
        if (start) begin
          if (k_legal) begin
            // The address for row 0 is loaded now, so ISSUE drives it from a register.
            k_d     = kernel_size;
            base_d  = base_addr;
            addr_d  = base_addr;
            state_d = S_ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        // Read data is only trusted here; valid seen in any other state is ignored.
        if (bram_rd_valid) begin
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (row_q == k_q - 5'd1) begin
          if (k_q < MAX_K_L) begin
            // row continues counting through the pad rows up to MAX_K-1.
            row_d   = row_q + 5'd1;
            state_d = S_PAD;
          end else begin
            state_d = S_COMMIT;
          end
        end else begin
          // The address wraps naturally modulo 2^AW.
          row_d   = row_q + 5'd1;
          addr_d  = base_q + AW'(row_q + 5'd1);
          state_d = S_ISSUE;
        end
      end

      S_PAD: begin
        if (row_q == MAX_K_L - 5'd1) begin
          state_d = S_COMMIT;
        end else begin
          row_d = row_q + 5'd1;
        end
      end

      S_COMMIT: begin
        row_d   = '0;
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore output decode from registered state.
  always_comb begin
    bram_rd_en          = 1'b0;
    load_weight_preload = 1'b0;
    zero_fill           = 1'b0;
    load_MAC_weight     = 1'b0;
    done                = 1'b0;
    busy                = (state_q != S_IDLE);
    bram_addr           = addr_q;
    err_kernel          = err_q;

    case (state_q)
      S_ISSUE:  bram_rd_en = 1'b1;
      S_SHIFT:  load_weight_preload = 1'b1;
      S_PAD: begin
        load_weight_preload = 1'b1;
        zero_fill           = 1'b1;
      end
      S_COMMIT: load_MAC_weight = 1'b1;
      S_DONE:   done = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Scoreboard bench for weight_load_ctrl.
// For every start it builds the cycle-exact event timeline of the load from the
// kernel size, the base row and the chosen BRAM response delays.
// A monitor checks every strobe the DUT shows against that timeline.
module tb_weight_load_ctrl;

  localparam int AW    = 12;
  localparam int MAX_K = 5;

  localparam int EV_READ   = 1;
  localparam int EV_SHIFT  = 2;
  localparam int EV_COMMIT = 3;
  localparam int EV_DONE   = 4;
  localparam int EV_ERR    = 5;
  localparam int EV_BAD    = 6;

  typedef struct {
    int     kind;
    int     val;
    longint cyc;
    bit     busy;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [4:0]    kernel_size;
  logic [AW-1:0] base_addr;
  logic          bram_rd_en;
  logic [AW-1:0] bram_addr;
  logic          bram_rd_valid;
  logic          load_weight_preload;
  logic          zero_fill;
  logic          load_MAC_weight;
  logic          busy;
  logic          done;
  logic          err_kernel;

  exp_t   exp_q[$];
  int     dq[$];
  longint cyc = 0;
  int     errors = 0;
  int     checks = 0;
  int     idle_req = 0;
  int     idle_ack = 0;
  bit     spur = 1'b0;
  int     wait_cnt = 0;
  logic [AW-1:0] last_addr = '0;

  weight_load_ctrl #(
    .BRAM_ADDRESS_WIDTH(AW),
    .MAX_K(MAX_K)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .kernel_size         (kernel_size),
    .base_addr           (base_addr),
    .bram_rd_en          (bram_rd_en),
    .bram_addr           (bram_addr),
    .bram_rd_valid       (bram_rd_valid),
    .load_weight_preload (load_weight_preload),
    .zero_fill           (zero_fill),
    .load_MAC_weight     (load_MAC_weight),
    .busy                (busy),
    .done                (done),
    .err_kernel          (err_kernel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM responder: valid arrives d cycles after the read request; optionally
  // a stray valid pulse is also driven during the ISSUE cycle itself.
  always @(negedge clk) begin
    if (!rst_n) begin
      dq.delete();
      wait_cnt = 0;
      bram_rd_valid = 1'b0;
    end else begin
      bram_rd_valid = 1'b0;
      if (wait_cnt > 0) begin
        wait_cnt = wait_cnt - 1;
        if (wait_cnt == 0) bram_rd_valid = 1'b1;
      end
      if (bram_rd_en) begin
        wait_cnt = (dq.size() > 0) ? dq.pop_front() : 1;
        if (spur) bram_rd_valid = 1'b1;
      end
    end
  end

  // Monitor: compares every observed strobe with the scoreboard.
  always @(negedge clk) begin
    int   n;
    int   okind;
    int   oval;
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      last_addr = '0;
      checks = checks + 1;
      if ({bram_rd_en, bram_addr, load_weight_preload, zero_fill, load_MAC_weight,
           busy, done, err_kernel} != '0) begin
        errors = errors + 1;
        $display("FAIL reset_outputs: got rd_en=%0b addr=%h pre=%0b zf=%0b mac=%0b busy=%0b done=%0b err=%0b, required all 0",
                 bram_rd_en, bram_addr, load_weight_preload, zero_fill, load_MAC_weight,
                 busy, done, err_kernel);
      end
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL missing_event: kind=%0d val=%0h required at cycle %0d, not seen by cycle %0d",
                 e.kind, e.val, e.cyc, cyc);
      end
      n = int'(bram_rd_en) + int'(load_weight_preload) + int'(load_MAC_weight) +
          int'(done) + int'(err_kernel) + int'(zero_fill & ~load_weight_preload);
      okind = EV_BAD;
      oval  = 0;
      if (bram_rd_en) begin
        okind = EV_READ;
        oval  = int'(bram_addr);
      end else if (load_weight_preload) begin
        okind = EV_SHIFT;
        oval  = int'(zero_fill);
      end else if (load_MAC_weight) okind = EV_COMMIT;
      else if (done)                okind = EV_DONE;
      else if (err_kernel)          okind = EV_ERR;
      if (n > 0) begin
        checks = checks + 1;
        if (n > 1) begin
          errors = errors + 1;
          $display("FAIL multi_strobe: got %0d strobes at cycle %0d, required 1", n, cyc);
        end else if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_event: got kind=%0d val=%0h at cycle %0d, required none",
                   okind, oval, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != okind || e.val != oval || e.cyc != cyc || e.busy != busy) begin
            errors = errors + 1;
            $display("FAIL event: got kind=%0d val=%0h cyc=%0d busy=%0b, required kind=%0d val=%0h cyc=%0d busy=%0b",
                     okind, oval, cyc, busy, e.kind, e.val, e.cyc, e.busy);
          end
        end
        if (load_weight_preload) begin
          checks = checks + 1;
          if (bram_addr != last_addr) begin
            errors = errors + 1;
            $display("FAIL addr_hold: got bram_addr=%h during shift, required %h", bram_addr, last_addr);
          end
        end
        if (bram_rd_en) last_addr = bram_addr;
      end
      if (idle_req != idle_ack) begin
        idle_ack = idle_req;
        checks = checks + 1;
        if (busy !== 1'b0) begin
          errors = errors + 1;
          $display("FAIL idle_busy: got busy=%0b at cycle %0d, required 0", busy, cyc);
        end
      end
    end
  end

  task automatic push_ev(input int kind, input int val, input longint c, input bit b);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    e.busy = b;
    exp_q.push_back(e);
  endtask

  // Build the expected timeline of a legal load and pulse start (called at a negedge).
  task automatic issue_load(input int k, input logic [AW-1:0] base,
                            input int dmin, input int dmax, input bit sp);
    longint        t;
    int            d;
    logic [AW-1:0] a;
    spur = sp;
    t = cyc + 1;
    for (int i = 0; i < k; i++) begin
      d = $urandom_range(dmax, dmin);
      dq.push_back(d);
      a = base + AW'(i);
      push_ev(EV_READ, int'(a), t, 1'b1);
      push_ev(EV_SHIFT, 0, t + 1 + d, 1'b1);
      t = t + d + 2;
    end
    for (int p = 0; p < MAX_K - k; p++) begin
      push_ev(EV_SHIFT, 1, t, 1'b1);
      t = t + 1;
    end
    push_ev(EV_COMMIT, 0, t, 1'b1);
    push_ev(EV_DONE, 0, t + 1, 1'b1);
    start       = 1'b1;
    kernel_size = 5'(k);
    base_addr   = base;
    @(negedge clk);
    start       = 1'b0;
    kernel_size = 5'($urandom);
    base_addr   = AW'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      $display("FAIL timeout: %0d expected events still pending at cycle %0d, required 0",
               exp_q.size(), cyc);
      $fatal(1, "scoreboard did not drain");
    end
    idle_req = idle_req + 1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic run_load(input int k, input logic [AW-1:0] base, input int dmin,
                          input int dmax, input bit sp, input bit rep);
    issue_load(k, base, dmin, dmax, sp);
    if (rep) begin
      repeat (2) @(negedge clk);
      start       = 1'b1;
      kernel_size = 5'd2;
      base_addr   = AW'($urandom);
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle();
  endtask

  task automatic run_err(input int k);
    push_ev(EV_ERR, 0, cyc + 1, 1'b0);
    start       = 1'b1;
    kernel_size = 5'(k);
    base_addr   = AW'($urandom);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    int  k;
    int  dmin;
    int  dmax;
    bit  sp;
    bit  rep;
    rst_n       = 1'b0;
    start       = 1'b0;
    kernel_size = '0;
    base_addr   = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    idle_req = idle_req + 1;
    @(negedge clk);

    // Directed cases.
    run_load(1, 12'h010, 1, 1, 1'b0, 1'b0);
    run_load(5, 12'h100, 3, 3, 1'b0, 1'b0);
    run_load(3, 12'hFFF, 1, 2, 1'b0, 1'b0);
    run_err(0);
    run_err(6);
    run_load(4, 12'h200, 2, 3, 1'b1, 1'b1);

    // Reset while waiting for read data, then a fresh load.
    issue_load(5, 12'h300, 10, 10, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    repeat (20) @(negedge clk);
    idle_req = idle_req + 1;
    @(negedge clk);
    run_load(2, 12'h0A0, 1, 3, 1'b0, 1'b0);

    // Randomized loads, illegal kernels mixed in.
    for (int it = 0; it < 30; it++) begin
      k = ($urandom_range(9, 0) == 0) ? $urandom_range(31, 8) : $urandom_range(7, 0);
      if (k >= 1 && k <= MAX_K) begin
        dmin = $urandom_range(3, 1);
        dmax = dmin + $urandom_range(2, 0);
        sp   = (dmin >= 2) && ($urandom_range(1, 0) == 1);
        rep  = ($urandom_range(3, 0) == 0);
        run_load(k, AW'($urandom), dmin, dmax, sp, rep);
      end else begin
        run_err(k);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
